// File: rtl/had_transform_stream.sv
// Streaming Walsh-Hadamard transform engine.
// Collects N = 2^LOG2N unsigned samples, runs an in-place butterfly network
// (one stage per cycle) and streams N signed coefficients in natural or
// sequency order.
//
// Handshakes: a sample is taken on a rising edge where wen && din_ready; a
// coefficient beat is consumed on a rising edge where dout_valid && dout_ready.
// While dout_valid is high and dout_ready is low, dout, dout_idx, dout_last and
// dout_valid hold their values.
module had_transform_stream #(
    parameter int DIN_W  = 4,
    parameter int LOG2N  = 2,
    parameter int DOUT_W = DIN_W + LOG2N + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIN_W-1:0]         din,
    input  logic                     wen,
    output logic                     din_ready,
    input  logic                     seq_mode,
    output logic signed [DOUT_W-1:0] dout,
    output logic [LOG2N-1:0]         dout_idx,
    output logic                     dout_valid,
    output logic                     dout_last,
    input  logic                     dout_ready,
    output logic                     busy,
    output logic                     drop_err,
    output logic [1:0]               state_dbg
);

    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [LOG2N-1:0]         wcnt;
    logic [LOG2N-1:0]         stage;
    logic [LOG2N-1:0]         kcnt;
    logic [LOG2N-1:0]         gray_k;
    logic [LOG2N-1:0]         rd_idx;
    logic                     seq_r;
    logic signed [DOUT_W-1:0] arr  [N];
    logic signed [DOUT_W-1:0] bfly [N];
    logic                     wr_acc;
    logic                     last_wr;
    logic                     last_stage;
    logic                     out_hs;
    logic                     last_beat;

    assign wr_acc     = wen && (state == COLLECT);
    assign last_wr    = wr_acc && (wcnt == LOG2N'(N - 1));
    assign last_stage = (state == COMPUTE) && (stage == LOG2N'(LOG2N - 1));
    assign out_hs     = (state == OUTPUT) && dout_ready;
    assign last_beat  = out_hs && (kcnt == LOG2N'(N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // Next-state logic: collect N samples, run LOG2N stages, drain N beats.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_wr)    state_nxt = COMPUTE;
            COMPUTE: if (last_stage) state_nxt = OUTPUT;
            OUTPUT:  if (last_beat)  state_nxt = COLLECT;
            default:                 state_nxt = COLLECT;
        endcase
    end

    // One butterfly stage: element i pairs with i ^ h, h = 2^stage.
    // The lower element of a pair takes the sum, the upper one the difference.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bfly[i] = arr[i];
            for (int s = 0; s < LOG2N; s++) begin
                if (stage == LOG2N'(s)) begin
                    if (((i >> s) & 1) == 0) bfly[i] = arr[i] + arr[i ^ (1 << s)];
                    else                     bfly[i] = arr[i ^ (1 << s)] - arr[i];
                end
            end
        end
    end

    // Read index: natural order, or bit-reversed Gray code for sequency order.
    always_comb begin
        gray_k = kcnt ^ (kcnt >> 1);
        rd_idx = kcnt;
        if (seq_r) begin
            for (int b = 0; b < LOG2N; b++) rd_idx[b] = gray_k[LOG2N-1-b];
        end
    end

    // Sample capture, butterfly update, output counter and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt     <= '0;
            stage    <= '0;
            kcnt     <= '0;
            seq_r    <= 1'b0;
            drop_err <= 1'b0;
            for (int i = 0; i < N; i++) arr[i] <= '0;
        end else begin
            if (wen && (state != COLLECT)) drop_err <= 1'b1;
            case (state)
                COLLECT: begin
                    stage <= '0;
                    if (wr_acc) begin
                        arr[wcnt] <= {{(DOUT_W-DIN_W){1'b0}}, din};
                        wcnt      <= wcnt + 1'b1;
                    end
                    if (last_wr) seq_r <= seq_mode;
                end
                COMPUTE: begin
                    for (int i = 0; i < N; i++) arr[i] <= bfly[i];
                    stage <= last_stage ? '0 : stage + 1'b1;
                    kcnt  <= '0;
                end
                OUTPUT: begin
                    if (out_hs) kcnt <= kcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign din_ready  = (state == COLLECT);
    assign busy       = (state != COLLECT);
    assign dout_valid = (state == OUTPUT);
    assign dout_idx   = kcnt;
    assign dout_last  = dout_valid && (kcnt == LOG2N'(N - 1));
    assign dout       = dout_valid ? arr[rd_idx] : '0;
    assign state_dbg  = state;

endmodule

// File: tb/tb_had_transform_stream.sv
// Bench for had_transform_stream: a 4-point instance and an 8-point instance
// share the stimulus; sel steers wen to one of them and picks which outputs
// are observed.
module tb_had_transform_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       wen;
    logic       seq_mode;
    logic       dout_ready;
    logic       sel;
    logic [3:0] din;

    logic              wen_a, din_ready_a, valid_a, last_a, busy_a, drop_a;
    logic signed [6:0] dout_a;
    logic [1:0]        idx_a, st_a;
    logic              wen_b, din_ready_b, valid_b, last_b, busy_b, drop_b;
    logic signed [7:0] dout_b;
    logic [2:0]        idx_b;
    logic [1:0]        st_b;

    logic signed [31:0] o_dout;
    logic [31:0]        o_idx;
    logic [1:0]         o_state;
    logic               o_valid, o_last, o_din_ready, o_busy, o_drop;

    int checks = 0;
    int errors = 0;
    int blk [16];
    logic signed [31:0] exp_q [$];
    logic signed [31:0] idx_q [$];

    // Clock.
    always #5 clk = ~clk;

    assign wen_a = wen & ~sel;
    assign wen_b = wen & sel;

    had_transform_stream #(.DIN_W(4), .LOG2N(2), .DOUT_W(7)) dut_a (
        .clk(clk), .rst(rst), .din(din), .wen(wen_a), .din_ready(din_ready_a),
        .seq_mode(seq_mode), .dout(dout_a), .dout_idx(idx_a), .dout_valid(valid_a),
        .dout_last(last_a), .dout_ready(dout_ready), .busy(busy_a),
        .drop_err(drop_a), .state_dbg(st_a)
    );

    had_transform_stream #(.DIN_W(4), .LOG2N(3), .DOUT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(din), .wen(wen_b), .din_ready(din_ready_b),
        .seq_mode(seq_mode), .dout(dout_b), .dout_idx(idx_b), .dout_valid(valid_b),
        .dout_last(last_b), .dout_ready(dout_ready), .busy(busy_b),
        .drop_err(drop_b), .state_dbg(st_b)
    );

    // Observed outputs of the selected instance.
    always_comb begin
        if (sel) begin
            o_dout = 32'(dout_b); o_idx = 32'(idx_b); o_valid = valid_b; o_last = last_b;
            o_din_ready = din_ready_b; o_busy = busy_b; o_drop = drop_b; o_state = st_b;
        end else begin
            o_dout = 32'(dout_a); o_idx = 32'(idx_a); o_valid = valid_a; o_last = last_a;
            o_din_ready = din_ready_a; o_busy = busy_a; o_drop = drop_a; o_state = st_a;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wen = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_din_ready"}, o_din_ready, 1);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_dout"}, o_dout, 0);
        check({tag, "_idx"}, o_idx, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_drop"}, o_drop, 0);
        check({tag, "_state"}, o_state, 0);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        blk[0] = a; blk[1] = b; blk[2] = c; blk[3] = d;
    endtask

    task automatic push(input int v, input int k);
        exp_q.push_back(v);
        idx_q.push_back(k);
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        push(a, 0); push(b, 1); push(c, 2); push(d, 3);
    endtask

    // Drive n samples from blk; seq_mode carries the wanted value only on
    // the final write and the opposite value otherwise.
    task automatic write_block(input int n, input bit seq, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(1, 7)) tick();
            din = 4'(blk[i]);
            seq_mode = (i == n - 1) ? seq : ~seq;
            wen = 1'b1;
            tick();
            wen = 1'b0;
            seq_mode = ~seq;
        end
    endtask

    // Reference: coefficient j is sum_i x[i] * (-1)^popcount(i&j); sequency
    // order lists the Walsh rows by their number of sign changes.
    task automatic model_block(input int n, input bit seq);
        int coef [16];
        int sc [16];
        for (int j = 0; j < n; j++) begin
            coef[j] = 0;
            sc[j] = 0;
            for (int i = 0; i < n; i++) begin
                coef[j] += ($countones(i & j) % 2 == 1) ? -blk[i] : blk[i];
                if (i > 0 && ($countones((i - 1) & j) % 2) != ($countones(i & j) % 2)) sc[j]++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (!seq) push(coef[k], k);
            else for (int j = 0; j < n; j++) if (sc[j] == k) push(coef[j], k);
        end
    endtask

    // Scoreboard: consume beats against exp_q under a ready pattern
    // (0 always ready, 1 stall 5 then toggle, 2 random).
    task automatic drain(input int mode);
        int cyc = 0;
        int vc = -1;
        bit stalled = 1'b0;
        logic signed [31:0] pd, pi, e, ei;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (o_valid && vc < 0) vc = 0;
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (vc >= 5) ? vc[0] : 1'b0;
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                check("stall_valid", o_valid, 1);
                check("stall_dout", o_dout, pd);
                check("stall_idx", o_idx, pi);
            end
            if (o_valid) begin
                check("din_ready_while_out", o_din_ready, 0);
                if (dout_ready) begin
                    e = exp_q.pop_front();
                    ei = idx_q.pop_front();
                    check("dout", o_dout, e);
                    check("dout_idx", o_idx, ei);
                    check("dout_last", o_last, (exp_q.size() == 0) ? 1 : 0);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = o_dout;
                    pi = o_idx;
                end
            end
            tick();
            cyc++;
            if (vc >= 0) vc++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout_left", exp_q.size(), 0);
            exp_q.delete();
            idx_q.delete();
        end
        check("post_valid", o_valid, 0);
        check("post_din_ready", o_din_ready, 1);
        dout_ready = 1'b1;
    endtask

    initial begin
        int cnt;
        int n;
        bit sq;
        rst = 1'b1; wen = 1'b0; din = '0; seq_mode = 1'b0; dout_ready = 1'b1; sel = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 0;

        // Reset state.
        do_reset();
        check_reset("reset");

        // Constant block with write gaps, plus first-output latency.
        set4(12, 12, 12, 12);
        write_block(4, 1'b0, 1'b1);
        check("lat_t0_valid", o_valid, 0);
        check("lat_t0_din_ready", o_din_ready, 0);
        check("lat_t0_busy", o_busy, 1);
        tick();
        check("lat_t1_valid", o_valid, 0);
        tick();
        check("lat_t2_valid", o_valid, 1);
        push4(48, 0, 0, 0);
        drain(0);

        // Ramp in both orders, and extreme values.
        set4(1, 2, 3, 4);
        write_block(4, 1'b0, 1'b0);
        push4(10, -2, -4, 0);
        drain(0);
        write_block(4, 1'b1, 1'b0);
        push4(10, -4, 0, -2);
        drain(0);
        set4(0, 15, 0, 15);
        write_block(4, 1'b0, 1'b1);
        push4(30, -30, 0, 0);
        drain(0);

        // Backpressure.
        set4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        write_block(4, 1'b1, 1'b0);
        model_block(4, 1'b1);
        drain(1);

        // Writes during COMPUTE and OUTPUT are dropped and flagged.
        set4(3, 1, 4, 1);
        write_block(4, 1'b0, 1'b0);
        din = 4'd15; wen = 1'b1;
        tick();
        wen = 1'b0;
        check("drop_in_compute", o_drop, 1);
        dout_ready = 1'b0;
        cnt = 0;
        while (!o_valid && cnt < 20) begin tick(); cnt++; end
        check("wait_output_valid", o_valid, 1);
        wen = 1'b1;
        tick();
        wen = 1'b0;
        check("drop_in_output", o_drop, 1);
        check("idx_held_after_drop", o_idx, 0);
        push4(9, 5, -1, -1);
        drain(0);
        check("drop_sticky", o_drop, 1);
        set4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        write_block(4, 1'b0, 1'b1);
        model_block(4, 1'b0);
        drain(2);
        check("drop_still_set", o_drop, 1);

        // Reset mid-collect, then mid-compute.
        set4(9, 9, 9, 9);
        write_block(2, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_collect");
        set4(5, 5, 5, 5);
        write_block(4, 1'b0, 1'b0);
        push4(20, 0, 0, 0);
        drain(0);
        set4(7, 3, 11, 2);
        write_block(4, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_compute");
        set4(5, 5, 5, 5);
        write_block(4, 1'b0, 1'b0);
        push4(20, 0, 0, 0);
        drain(0);

        // Eight-point instance.
        sel = 1'b1;
        do_reset();
        check_reset("reset8");
        for (int i = 0; i < 8; i++) blk[i] = (i == 0) ? 15 : 0;
        write_block(8, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) push(15, k);
        drain(0);
        for (int i = 0; i < 8; i++) blk[i] = 15;
        write_block(8, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) push((k == 0) ? 120 : 0, k);
        drain(1);
        for (int i = 0; i < 8; i++) blk[i] = $urandom_range(0, 15);
        write_block(8, 1'b1, 1'b0);
        model_block(8, 1'b1);
        drain(2);

        // Random blocks across both instances and orders.
        repeat (8) begin
            sel = 1'($urandom_range(0, 1));
            n = sel ? 8 : 4;
            sq = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) blk[i] = $urandom_range(0, 15);
            write_block(n, sq, 1'($urandom_range(0, 1)));
            model_block(n, sq);
            drain($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
